fetch_sequencer: RTL and testbench

- Front stage of the multicycle ARM-subset core. Directly upstream of the execute/cycle-control stage.
- Owns the program counter, the instruction register (IR) and the 2-bit cycle state.
- Fetches one word per instruction from instruction memory, decodes the IR into the field bus the execute stage consumes, and applies the branch request (bf, branchimm) that the execute stage returns.

---
 rtl/cpu_pkg.sv | 104 ++++++++++
 rtl/instr_decode.sv | 45 ++++
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Definitions shared by the fetch/decode and execute stages of
//               the multicycle ARM-subset core. Holds the cycle-state
//               encoding, IR field bit positions, the decoded-field bus type,
//               data-processing opcodes, condition codes and the branch
//               target helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Cycle state encoding
  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_READ  = 2'b01;
  localparam logic [1:0] S_SHIFT = 2'b10;
  localparam logic [1:0] S_WB    = 2'b11;

  // IR field bit positions
  localparam int COND_MSB = 31;
  localparam int COND_LSB = 28;
  localparam int TYPE_MSB = 27;   // instruction class bits IR[27:25]
  localparam int TYPE_LSB = 25;
  localparam int T_BIT    = 25;
  localparam int OP_MSB   = 24;
  localparam int OP_LSB   = 21;
  localparam int P_BIT    = 24;
  localparam int U_BIT    = 23;
  localparam int B_BIT    = 22;
  localparam int W_BIT    = 21;
  localparam int S_BIT    = 20;
  localparam int RN_MSB   = 19;
  localparam int RN_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 12;
  localparam int OPND_MSB = 11;
  localparam int RM_MSB   = 3;
  localparam int OFS_MSB  = 23;

  // Data-processing opcodes
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;

  // Decoded field bus. bbit is IR[22] (byte / S-bit position).
  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  op;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [11:0] operand;
    logic [23:0] offset;
    logic        b;
    logic        l;
    logic        t;
    logic        s;
    logic        ldr;
    logic        str;
    logic        p;
    logic        u;
    logic        bbit;
    logic        w;
  } decode_t;

  // Branch target: the word offset is relative to pc plus the pipeline offset.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [31:0] ahead,
                                                input logic [31:0] imm);
    return pc + ahead + (imm << 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Purely combinational IR -> decoded field bus.
// Ports       : ir  in  32      instruction register
//               dec out decode_t decoded fields and class flags
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output decode_t     dec
);

  logic [2:0] w_type;
  logic       w_mem;

  assign w_type = ir[TYPE_MSB:TYPE_LSB];
  // Single data transfer class is IR[27:26]==01 regardless of IR[25]
  assign w_mem  = (w_type[2:1] == 2'b01);

  always_comb begin
    dec         = '0;
    dec.cond    = ir[COND_MSB:COND_LSB];
    dec.t       = ir[T_BIT];
    dec.op      = ir[OP_MSB:OP_LSB];
    dec.s       = ir[S_BIT];
    dec.rn      = ir[RN_MSB:RN_LSB];
    dec.rd      = ir[RD_MSB:RD_LSB];
    dec.operand = ir[OPND_MSB:0];
    dec.rm      = ir[RM_MSB:0];
    dec.offset  = ir[OFS_MSB:0];
    dec.p       = ir[P_BIT];
    dec.u       = ir[U_BIT];
    dec.bbit    = ir[B_BIT];
    dec.w       = ir[W_BIT];
    dec.b       = (w_type == 3'b101);
    dec.l       = (w_type == 3'b101) & ir[P_BIT];
    dec.ldr     = w_mem &  ir[S_BIT];
    dec.str     = w_mem & ~ir[S_BIT];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Front stage of the multicycle core. Owns pc, IR and the
//               2-bit cycle state; fetches one word per instruction, decodes
//               IR and applies the branch request from the execute stage.
// Ports       : clk, reset (sync, active-high), hold (stall)
//               imem_data/imem_addr/imem_rd : instruction memory interface
//               bf, branchimm               : branch request (state 11 only)
//               pc, state, instr_count      : architectural status
//               cond..w                     : decoded IR fields
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] PC_AHEAD = 32'd8
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic [31:0] imem_data,
  input  logic        bf,
  input  logic [31:0] branchimm,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  output logic [31:0] pc,
  output logic [1:0]  state,
  output logic [3:0]  cond,
  output logic [3:0]  op,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic [11:0] operand,
  output logic [23:0] offset,
  output logic        b,
  output logic        l,
  output logic        t,
  output logic        s,
  output logic        ldr,
  output logic        str,
  output logic        p,
  output logic        u,
  output logic        bbit,
  output logic        w,
  output logic [31:0] instr_count
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_count;
  decode_t     w_dec;

  // pc and instr_count only move on the write-back exit edge, so a reset
  // anywhere earlier in the instruction leaves no partial update behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= PC_RESET;
      r_ir    <= '0;
      r_count <= '0;
    end else if (!hold) begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= imem_data;
          r_state <= S_READ;
        end
        S_READ:  r_state <= S_SHIFT;
        S_SHIFT: r_state <= S_WB;
        S_WB: begin
          r_pc    <= bf ? branch_target(r_pc, PC_AHEAD, branchimm)
                        : r_pc + PC_STEP;
          r_count <= r_count + 32'd1;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  instr_decode u_decode (
    .ir  (r_ir),
    .dec (w_dec)
  );

  assign imem_addr   = r_pc;
  assign imem_rd     = (r_state == S_FETCH);
  assign pc          = r_pc;
  assign state       = r_state;
  assign instr_count = r_count;

  assign cond    = w_dec.cond;
  assign op      = w_dec.op;
  assign rn      = w_dec.rn;
  assign rd      = w_dec.rd;
  assign rm      = w_dec.rm;
  assign operand = w_dec.operand;
  assign offset  = w_dec.offset;
  assign b       = w_dec.b;
  assign l       = w_dec.l;
  assign t       = w_dec.t;
  assign s       = w_dec.s;
  assign ldr     = w_dec.ldr;
  assign str     = w_dec.str;
  assign p       = w_dec.p;
  assign u       = w_dec.u;
  assign bbit    = w_dec.bbit;
  assign w       = w_dec.w;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. A phase-counting
//               reference model tracks pc, IR and the retired count; decoded
//               fields are recomputed from the instruction word arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, hold, bf;
  logic [31:0] imem_data, branchimm;
  logic [31:0] imem_addr, pc, instr_count;
  logic        imem_rd;
  logic [1:0]  state;
  logic [3:0]  cond, op, rn, rd, rm;
  logic [11:0] operand;
  logic [23:0] offset;
  logic        b, l, t, s, ldr, str, p, u, bbit, w;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  int          m_phase;
  logic [31:0] m_pc, m_ir, m_cnt;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .hold(hold), .imem_data(imem_data),
    .bf(bf), .branchimm(branchimm), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .pc(pc), .state(state), .cond(cond), .op(op),
    .rn(rn), .rd(rd), .rm(rm), .operand(operand), .offset(offset),
    .b(b), .l(l), .t(t), .s(s), .ldr(ldr), .str(str), .p(p), .u(u),
    .bbit(bbit), .w(w), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Expected decode bus {cond,op,rn,rd,rm,operand,offset,b,l,t,s,ldr,str,p,u,bbit,w}
  function automatic logic [65:0] exp_fields(input logic [31:0] ir);
    int cls, is_b, is_mem;
    cls    = int'((ir >> 25) & 32'h7);
    is_b   = (cls == 5) ? 1 : 0;
    is_mem = (cls / 2 == 1) ? 1 : 0;
    return {4'((ir >> 28) & 32'hF), 4'((ir >> 21) & 32'hF),
            4'((ir >> 16) & 32'hF), 4'((ir >> 12) & 32'hF),
            4'(ir & 32'hF), 12'(ir & 32'hFFF), 24'(ir & 32'hFF_FFFF),
            1'(is_b), 1'(is_b & int'((ir >> 24) & 1)), 1'((ir >> 25) & 1),
            1'((ir >> 20) & 1), 1'(is_mem & int'((ir >> 20) & 1)),
            1'(is_mem & int'(~(ir >> 20) & 1)), 1'((ir >> 24) & 1),
            1'((ir >> 23) & 1), 1'((ir >> 22) & 1), 1'((ir >> 21) & 1)};
  endfunction

  // One clock: drive inputs, advance the model on the edge, sample at negedge.
  task automatic tick(input logic h, input logic bfi, input logic [31:0] imm,
                      input logic r);
    reset = r; hold = h; bf = bfi; branchimm = imm;
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_pc = 32'h0; m_ir = 32'h0; m_cnt = 32'h0;
    end else if (!h) begin
      if (m_phase == 0) m_ir = imem_data;
      if (m_phase == 3) begin
        m_pc  = bfi ? m_pc + 32'd8 + imm * 32'd4 : m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
      m_phase = (m_phase + 1) % 4;
    end
    @(negedge clk);
    reset = 1'b0; hold = 1'b0; bf = 1'b0;
  endtask

  // Runs a whole non-branching instruction.
  task automatic run_seq(input logic [31:0] instr);
    imem_data = instr;
    repeat (4) tick(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset;
    imem_data = 32'hE1A0_0000;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({state, pc, instr_count, imem_rd} !== {2'b00, 32'h0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got st=%b pc=%h cnt=%h rd=%b want 00/0/0/1",
               state, pc, instr_count, imem_rd);
    end
    n_checks++;
    if ({cond, op, offset, b, ldr, str} !== '0) begin
      n_fail++;
      $display("FAIL reset_ir got cond=%h op=%h ofs=%h want zero IR fields",
               cond, op, offset);
    end
  endtask

  task automatic test_sequential;
    logic [1:0] exp_st [3] = '{2'b01, 2'b10, 2'b11};
    imem_data = 32'hE081_0002;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      n_checks++;
      if (state !== exp_st[i] || imem_rd !== 1'b0 || pc !== 32'h0) begin
        n_fail++;
        $display("FAIL seq_state%0d got st=%b rd=%b pc=%h want %b/0/0",
                 i, state, imem_rd, pc, exp_st[i]);
      end
    end
    n_checks++;
    if ({op, rn, rd, rm, t, s, cond} !== {OP_ADD, 4'd1, 4'd0, 4'd2, 1'b0, 1'b0, CC_AL}) begin
      n_fail++;
      $display("FAIL seq_decode got op=%h rn=%h rd=%h rm=%h t=%b s=%b want 4/1/0/2/0/0",
               op, rn, rd, rm, t, s);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({state, pc, instr_count, imem_rd} !== {2'b00, 32'h4, 32'h1, 1'b1}) begin
      n_fail++;
      $display("FAIL seq_retire got st=%b pc=%h cnt=%h rd=%b want 00/4/1/1",
               state, pc, instr_count, imem_rd);
    end
  endtask

  task automatic test_branch_fwd;
    repeat (3) run_seq(32'hE1A0_0000);
    n_checks++;
    if (pc !== 32'h10 || imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL bfwd_start got pc=%h addr=%h want 10", pc, imem_addr);
    end
    imem_data = 32'hEA00_0002;
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({b, l, offset, ldr, str} !== {1'b1, 1'b0, 24'h2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL bfwd_decode got b=%b l=%b ofs=%h want 1/0/000002", b, l, offset);
    end
    tick(1'b0, 1'b1, 32'h2, 1'b0);
    n_checks++;
    if (pc !== 32'h20) begin
      n_fail++;
      $display("FAIL bfwd_pc got %h want 00000020", pc);
    end
  endtask

  task automatic test_branch_back;
    imem_data = 32'hEAFF_FFFC;
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    n_checks++;
    if (pc !== 32'h18) begin
      n_fail++;
      $display("FAIL bback_pc got %h want 00000018", pc);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    imem_data = 32'hEAFF_FFFE;
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    n_checks++;
    if (pc !== 32'h0 || instr_count !== 32'h1) begin
      n_fail++;
      $display("FAIL bback_zero got pc=%h cnt=%h want 0/1", pc, instr_count);
    end
  endtask

  task automatic test_bf_outside_wb;
    logic [31:0] pc0;
    pc0 = pc;
    imem_data = 32'hE1A0_0000;
    tick(1'b0, 1'b1, 32'h40, 1'b0);   // leaving 00
    tick(1'b0, 1'b1, 32'h40, 1'b0);   // leaving 01
    tick(1'b0, 1'b1, 32'h40, 1'b0);   // leaving 10
    tick(1'b0, 1'b0, 32'h40, 1'b0);   // leaving 11, bf low
    n_checks++;
    if (pc !== pc0 + 32'd4) begin
      n_fail++;
      $display("FAIL bf_ignored got pc=%h want %h", pc, pc0 + 32'd4);
    end
  endtask

  task automatic test_ldst_decode;
    imem_data = 32'hE591_2000;
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({ldr, str, p, u, rn, rd, b} !== {1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL ldr_decode got ldr=%b str=%b p=%b u=%b rn=%h rd=%h want 1/0/1/1/1/2",
               ldr, str, p, u, rn, rd);
    end
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0);
    imem_data = 32'hE581_2000;
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({ldr, str} !== 2'b01) begin
      n_fail++;
      $display("FAIL str_decode got ldr=%b str=%b want 0/1", ldr, str);
    end
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_hold;
    logic [31:0] pc0;
    pc0 = pc;
    imem_data = 32'hE081_0002;
    repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0);
    imem_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 32'h0, 1'b0);
      n_checks++;
      if (state !== 2'b10 || pc !== pc0 || rm !== 4'd2 || op !== OP_ADD) begin
        n_fail++;
        $display("FAIL hold_freeze%0d got st=%b pc=%h rm=%h want 10/%h/2",
                 i, state, pc, rm, pc0);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (state !== 2'b11) begin
      n_fail++;
      $display("FAIL hold_resume got st=%b want 11", state);
    end
    tick(1'b1, 1'b1, 32'h10, 1'b0);   // hold beats bf in write-back
    tick(1'b0, 1'b0, 32'h10, 1'b0);
    n_checks++;
    if (pc !== pc0 + 32'd4 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_bf got pc=%h st=%b want %h/00", pc, state, pc0 + 32'd4);
    end
  endtask

  task automatic test_reset_mid;
    imem_data = 32'hE1A0_0000;
    repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h7, 1'b1);
    n_checks++;
    if ({state, pc, instr_count, imem_rd} !== {2'b00, 32'h0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid got st=%b pc=%h cnt=%h rd=%b want 00/0/0/1",
               state, pc, instr_count, imem_rd);
    end
  endtask

  task automatic test_random;
    logic [31:0] imm;
    logic [65:0] got;
    for (int i = 0; i < 1200; i++) begin
      if (m_phase == 0) imem_data = $urandom;
      imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), imm,
           ($urandom_range(0, 99) == 0));
      n_checks++;
      if (state !== 2'(m_phase) || pc !== m_pc || imem_addr !== m_pc ||
          instr_count !== m_cnt || imem_rd !== (m_phase == 0)) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d] got st=%b pc=%h cnt=%h rd=%b want %0d/%h/%h",
                 i, state, pc, instr_count, imem_rd, m_phase, m_pc, m_cnt);
      end
      got = {cond, op, rn, rd, rm, operand, offset, b, l, t, s, ldr, str, p, u, bbit, w};
      n_checks++;
      if (got !== exp_fields(m_ir)) begin
        n_fail++;
        $display("FAIL rand_decode[%0d] ir=%h got %h want %h",
                 i, m_ir, got, exp_fields(m_ir));
      end
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; bf = 1'b0;
    branchimm = 32'h0; imem_data = 32'h0;
    m_phase = 0; m_pc = 32'h0; m_ir = 32'h0; m_cnt = 32'h0;
    @(negedge clk);
    test_reset;
    test_sequential;
    test_branch_fwd;
    test_branch_back;
    test_bf_outside_wb;
    test_ldst_decode;
    test_hold;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
